ov_cfg_sequencer: RTL and testbench

//  Walks a camera register-init table and drives the SCCB/I2C write engine, one 24-bit
//  {reg_addr[15:0], reg_data[7:0]} entry per transfer. Generates the engine's clock_en

---
 rtl/ov_cfg_sequencer_if.sv | 33 +++
 rtl/ov_cfg_sequencer.sv | 178 +++++++++++++++++
 tb/tb_ov_cfg_sequencer.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ov_cfg_sequencer_if.sv
// Bus bundle between the camera init-table sequencer and its environment
// (register ROM, SCCB/I2C write engine, power-up control), plus FSM debug state.
interface ov_cfg_sequencer_if #(
  parameter int ADDR_W = 9
);
  // Engine handshake: iic_start is held high for exactly one full clock_en tick
  // with iic_data stable; the engine then raises iic_done (level). iic_done is
  // only honoured while waiting for completion and while iic_start is low.
  logic              start;
  logic [ADDR_W-1:0] tbl_addr;
  logic [23:0]       tbl_data;
  logic              iic_clk_en;
  logic [23:0]       iic_data;
  logic              iic_enable;
  logic              iic_start;
  logic              iic_done;
  logic              busy;
  logic              cfg_done;
  logic              cfg_err;
  logic [3:0]        dbg_state;

  modport master (
    input  start, tbl_data, iic_done,
    output tbl_addr, iic_clk_en, iic_data, iic_enable, iic_start,
           busy, cfg_done, cfg_err, dbg_state
  );

  modport slave (
    output start, tbl_data, iic_done,
    input  tbl_addr, iic_clk_en, iic_data, iic_enable, iic_start,
           busy, cfg_done, cfg_err, dbg_state
  );
endinterface

// File: rtl/ov_cfg_sequencer.sv
// Camera register-init sequencer: walks a sync-ROM table and feeds one 24-bit entry per
// SCCB/I2C write transfer. Optional WAIT timeout/ERROR state under OV_CFG_TIMEOUT_EN.
module ov_cfg_sequencer #(
  parameter int CLK_DIV     = 250,
  parameter int ADDR_W      = 9,
  parameter int PWRUP_TICKS = 20000,
  parameter int GAP_TICKS   = 8,
  parameter int DLY_UNIT    = 100
) (
  input  logic                clock_in,
  input  logic                reset_in,
  ov_cfg_sequencer_if.master  bus
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int TMO_TICKS = 256;
  localparam int CNT_MAX   = max2(max2(PWRUP_TICKS, 255 * DLY_UNIT), max2(GAP_TICKS, TMO_TICKS));
  localparam int CNT_W     = $clog2(CNT_MAX + 1);
  localparam int DIV_W     = $clog2(CLK_DIV);

  typedef enum logic [3:0] {
    S_IDLE, S_PWRUP, S_FETCH, S_DECODE, S_START,
    S_PULSE, S_WAIT, S_GAP, S_DELAY, S_DONE, S_ERROR
  } state_t;

  state_t            state, state_n;
  logic [DIV_W-1:0]  div_cnt;
  logic              tick;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_val;
  logic              cnt_ld;
  logic              expire;
  logic [ADDR_W-1:0] ptr;
  logic              ptr_clr;
  logic              ptr_inc;
  logic [23:0]       data_q;
  logic              data_ld;
  logic [15:0]       entry_addr;
  logic              seq_active;

  // Free-running tick divider, independent of the sequencer state.
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign tick = (div_cnt == DIV_W'(CLK_DIV - 1));

  // A wait loaded with N finishes on its N-th tick; a zero load finishes at once.
  assign expire     = (cnt == '0) || (tick && (cnt == CNT_W'(1)));
  assign entry_addr = bus.tbl_data[23:8];

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_ld  = 1'b0;
    cnt_val = '0;
    ptr_clr = 1'b0;
    ptr_inc = 1'b0;
    data_ld = 1'b0;
    case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (bus.start) begin
          state_n = S_PWRUP;
          cnt_ld  = 1'b1;
          cnt_val = CNT_W'(PWRUP_TICKS);
          ptr_clr = 1'b1;
        end
      end
      S_PWRUP: begin
        if (expire) state_n = S_FETCH;
      end
      S_FETCH: state_n = S_DECODE;
      S_DECODE: begin
        if (entry_addr == 16'hFFFF) begin
          state_n = S_DONE;
        end else if (entry_addr == 16'hFFFE) begin
          state_n = S_DELAY;
          cnt_ld  = 1'b1;
          cnt_val = CNT_W'(bus.tbl_data[7:0]) * CNT_W'(DLY_UNIT);
        end else begin
          state_n = S_START;
          data_ld = 1'b1;
        end
      end
      S_START: begin
        if (tick) state_n = S_PULSE;
      end
      S_PULSE: begin
        if (tick) begin
          state_n = S_WAIT;
`ifdef OV_CFG_TIMEOUT_EN
          cnt_ld  = 1'b1;
          cnt_val = CNT_W'(TMO_TICKS);
`endif
        end
      end
      S_WAIT: begin
        if (bus.iic_done) begin
          state_n = S_GAP;
          cnt_ld  = 1'b1;
          cnt_val = CNT_W'(GAP_TICKS);
        end
`ifdef OV_CFG_TIMEOUT_EN
        else if (expire) begin
          state_n = S_ERROR;
        end
`endif
      end
      S_GAP, S_DELAY: begin
        // The last table slot has no successor: finish rather than wrap to entry 0.
        if (expire) begin
          if (ptr == '1) begin
            state_n = S_DONE;
          end else begin
            state_n = S_FETCH;
            ptr_inc = 1'b1;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      cnt    <= '0;
      ptr    <= '0;
      data_q <= '0;
    end else begin
      if (cnt_ld) begin
        cnt <= cnt_val;
      end else if (tick && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end
      if (ptr_clr) begin
        ptr <= '0;
      end else if (ptr_inc) begin
        ptr <= ptr + 1'b1;
      end
      if (data_ld) begin
        data_q <= bus.tbl_data;
      end
    end
  end

  // Outputs decode straight from the async-reset state so reset releases the bus at once.
  assign seq_active     = !((state == S_IDLE) || (state == S_DONE) || (state == S_ERROR));
  assign bus.tbl_addr   = ptr;
  assign bus.iic_clk_en = tick;
  assign bus.iic_data   = data_q;
  assign bus.iic_start  = (state == S_PULSE);
  assign bus.iic_enable = seq_active;
  assign bus.busy       = seq_active;
  assign bus.cfg_done   = (state == S_DONE);
  assign bus.dbg_state  = state;
`ifdef OV_CFG_TIMEOUT_EN
  assign bus.cfg_err    = (state == S_ERROR);
`else
  assign bus.cfg_err    = 1'b0;
`endif

endmodule

// File: tb/tb_ov_cfg_sequencer.sv
// Bench for ov_cfg_sequencer: directed steps plus randomized tables, with an engine model,
// a table-walk reference model feeding an expected-transfer queue, and tick-count checks.
module tb_ov_cfg_sequencer;

  localparam int CLK_DIV     = 4;
  localparam int ADDR_W      = 3;
  localparam int DEPTH       = 1 << ADDR_W;
  localparam int PWRUP_TICKS = 5;
  localparam int GAP_TICKS   = 2;
  localparam int DLY_UNIT    = 10;

  logic clock_in;
  logic reset_in;

  ov_cfg_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  ov_cfg_sequencer #(
    .CLK_DIV(CLK_DIV), .ADDR_W(ADDR_W), .PWRUP_TICKS(PWRUP_TICKS),
    .GAP_TICKS(GAP_TICKS), .DLY_UNIT(DLY_UNIT)
  ) dut (
    .clock_in(clock_in),
    .reset_in(reset_in),
    .bus(bus)
  );

  // ---------------- clock / reset ----------------
  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  initial begin
    #600000;
    $display("FAIL watchdog: time limit reached, observed unfinished run, expected summary");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int          vectors     = 0;
  int          miscompares = 0;
  logic [23:0] exp_q[$];
  logic [23:0] rom [DEPTH];
  logic        eng_respond = 1'b1;
  int          eng_min_lat = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: the transfers a table should produce, in order.
  task automatic model_push();
    for (int p = 0; p < DEPTH; p++) begin
      if (rom[p][23:8] == 16'hFFFF) break;
      if (rom[p][23:8] != 16'hFFFE) exp_q.push_back(rom[p]);
    end
  endtask

  always @(posedge clock_in) bus.tbl_data <= rom[bus.tbl_addr];

  // ---------------- engine model ----------------
  initial begin : engine
    logic [23:0]       xdata;
    logic [ADDR_W-1:0] a0;
    logic              last_en;
    int                width, ticks, lat, g, n;
    bus.iic_done = 1'b0;
    last_en = 1'b0;
    forever begin
      @(negedge clock_in);
      if (bus.iic_start !== 1'b1) begin
        last_en = bus.iic_clk_en;
        continue;
      end
      chk("start_after_tick", 32'(last_en), 32'd1);
      xdata = bus.iic_data;
      if (exp_q.size() == 0) chk("sb_extra_xfer", 32'(xdata), 32'hFFFF_FFFF);
      else chk("sb_data", 32'(xdata), 32'(exp_q.pop_front()));
      width = 1;
      ticks = int'(bus.iic_clk_en);
      n = 0;
      while (n < 4 * CLK_DIV) begin
        @(negedge clock_in);
        if (bus.iic_start !== 1'b1) break;
        width++;
        ticks += int'(bus.iic_clk_en);
        n++;
      end
      chk("start_width", 32'(width), 32'(CLK_DIV));
      chk("start_ticks", 32'(ticks), 32'd1);
      lat = int'($urandom_range(eng_min_lat, eng_min_lat + 5));
      repeat (lat) @(negedge clock_in);
      if (eng_respond && bus.busy === 1'b1) begin
        chk("data_stable", 32'(bus.iic_data), 32'(xdata));
        bus.iic_done = 1'b1;
        @(negedge clock_in);
        bus.iic_done = 1'b0;
        a0 = bus.tbl_addr;
        g = 0;
        n = 0;
        while (bus.tbl_addr === a0 && bus.cfg_done !== 1'b1 && bus.busy === 1'b1 && n < 64 * CLK_DIV) begin
          g += int'(bus.iic_clk_en);
          n++;
          @(negedge clock_in);
        end
        chk("gap_ticks", 32'(g), 32'(GAP_TICKS));
      end
      last_en = bus.iic_clk_en;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start();
    @(negedge clock_in);
    bus.start = 1'b1;
    @(negedge clock_in);
    bus.start = 1'b0;
  endtask

  task automatic run_to_end(input string tag, output int max_addr);
    int n;
    n = 0;
    max_addr = 0;
    while (bus.cfg_done !== 1'b1 && bus.cfg_err !== 1'b1 && n < 4000) begin
      if (int'(bus.tbl_addr) > max_addr) max_addr = int'(bus.tbl_addr);
      @(negedge clock_in);
      n++;
    end
    chk({tag, "_finished"}, 32'(n < 4000), 32'd1);
    chk({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_pulse_over(input string tag);
    int n;
    n = 0;
    while (bus.iic_start !== 1'b1 && n < 2000) begin
      @(negedge clock_in);
      n++;
    end
    chk({tag, "_start_seen"}, 32'(n < 2000), 32'd1);
    n = 0;
    while (bus.iic_start === 1'b1 && n < 100) begin
      @(negedge clock_in);
      n++;
    end
  endtask

  task automatic load_t2();
    for (int i = 0; i < DEPTH; i++) rom[i] = {16'($urandom_range(0, 16'hFFFD)), 8'($urandom)};
    rom[0] = 24'h0100_01;
    rom[1] = 24'h3503_07;
    rom[2] = 24'hFFFF_00;
  endtask

  // ---------------- directed sequence ----------------
  initial begin : main
    int mx, n, t;
    logic saw_start;
    reset_in  = 1'b1;
    bus.start = 1'b0;
    for (int i = 0; i < DEPTH; i++) rom[i] = 24'hFFFF_00;
    repeat (3) @(negedge clock_in);

    // reset state
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_cfg_done", 32'(bus.cfg_done), 0);
    chk("rst_cfg_err", 32'(bus.cfg_err), 0);
    chk("rst_iic_enable", 32'(bus.iic_enable), 0);
    chk("rst_iic_start", 32'(bus.iic_start), 0);
    chk("rst_clk_en", 32'(bus.iic_clk_en), 0);
    chk("rst_tbl_addr", 32'(bus.tbl_addr), 0);
    chk("rst_iic_data", 32'(bus.iic_data), 0);

    // T1: divider phase from reset release
    reset_in = 1'b0;
    for (int i = 0; i < 4 * CLK_DIV; i++) begin
      chk("clk_en_phase", 32'(bus.iic_clk_en), 32'((i % CLK_DIV) == CLK_DIV - 1));
      @(negedge clock_in);
    end

    // T2: basic table, power-up length, end marker
    load_t2();
    model_push();
    pulse_start();
    chk("t2_busy", 32'(bus.busy), 1);
    chk("t2_enable", 32'(bus.iic_enable), 1);
    t = 0;
    n = 0;
    while (bus.iic_start !== 1'b1 && n < 500) begin
      t += int'(bus.iic_clk_en);
      n++;
      @(negedge clock_in);
    end
    // Power-up ticks, plus the tick START waits for (FETCH/DECODE fit between ticks).
    chk("t2_pwrup_ticks", 32'(t), 32'(PWRUP_TICKS + 1));
    run_to_end("t2", mx);
    chk("t2_max_addr", 32'(mx), 2);
    chk("t2_cfg_done", 32'(bus.cfg_done), 1);
    chk("t2_busy_low", 32'(bus.busy), 0);
    chk("t2_enable_low", 32'(bus.iic_enable), 0);

    // T4: replay from DONE; start during WAIT ignored
    eng_min_lat = 3;
    model_push();
    pulse_start();
    chk("t4_busy", 32'(bus.busy), 1);
    chk("t4_done_clr", 32'(bus.cfg_done), 0);
    chk("t4_addr0", 32'(bus.tbl_addr), 0);
    wait_pulse_over("t4");
    pulse_start();
    chk("t4_busy_kept", 32'(bus.busy), 1);
    run_to_end("t4", mx);
    chk("t4_cfg_done", 32'(bus.cfg_done), 1);
    eng_min_lat = 0;

    // T3: delay entry of 5 units
    rom[0] = 24'h0100_01;
    rom[1] = 24'hFFFE_05;
    rom[2] = 24'h3503_07;
    rom[3] = 24'hFFFF_00;
    model_push();
    pulse_start();
    n = 0;
    while (bus.tbl_addr !== ADDR_W'(1) && n < 1000) begin
      @(negedge clock_in);
      n++;
    end
    chk("t3_reach_delay", 32'(n < 1000), 1);
    repeat (2) @(negedge clock_in);
    t = 0;
    n = 0;
    saw_start = 1'b0;
    while (bus.tbl_addr === ADDR_W'(1) && n < 1000) begin
      t += int'(bus.iic_clk_en);
      if (bus.iic_start === 1'b1) saw_start = 1'b1;
      n++;
      @(negedge clock_in);
    end
    chk("t3_delay_ticks", 32'(t), 32'(5 * DLY_UNIT));
    chk("t3_no_start", 32'(saw_start), 0);
    run_to_end("t3", mx);

    // Pointer overflow: full table without end marker
    for (int i = 0; i < DEPTH; i++) rom[i] = {16'($urandom_range(0, 16'hFFFD)), 8'($urandom)};
    model_push();
    pulse_start();
    run_to_end("ovf", mx);
    chk("ovf_max_addr", 32'(mx), 32'(DEPTH - 1));
    chk("ovf_cfg_done", 32'(bus.cfg_done), 1);
    repeat (20 * CLK_DIV) @(negedge clock_in);
    chk("ovf_no_wrap", 32'(bus.tbl_addr), 32'(DEPTH - 1));
    chk("ovf_idle_start", 32'(bus.iic_start), 0);

    // Randomized tables, including zero-length delays and early end markers
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < DEPTH; i++) begin
        n = int'($urandom_range(0, 99));
        if (n < 70)      rom[i] = {16'($urandom_range(0, 16'hFFFD)), 8'($urandom)};
        else if (n < 88) rom[i] = {16'hFFFE, 8'($urandom_range(0, 3))};
        else             rom[i] = {16'hFFFF, 8'($urandom)};
      end
      model_push();
      pulse_start();
      run_to_end("rnd", mx);
      chk("rnd_cfg_done", 32'(bus.cfg_done), 1);
    end

    // T5: reset mid-WAIT, then replay
    load_t2();
    eng_respond = 1'b0;
    model_push();
    pulse_start();
    wait_pulse_over("t5");
    repeat (5) @(negedge clock_in);
    #1 reset_in = 1'b1;
    #1;
    chk("t5_enable_async", 32'(bus.iic_enable), 0);
    chk("t5_start_async", 32'(bus.iic_start), 0);
    chk("t5_busy_async", 32'(bus.busy), 0);
    exp_q.delete();
    repeat (2) @(negedge clock_in);
    reset_in = 1'b0;
    eng_respond = 1'b1;
    model_push();
    pulse_start();
    chk("t5_addr0", 32'(bus.tbl_addr), 0);
    run_to_end("t5", mx);
    chk("t5_cfg_done", 32'(bus.cfg_done), 1);

    // T6: engine never answers
    rom[0] = 24'h1234_56;
    rom[1] = 24'hFFFF_00;
    eng_respond = 1'b0;
    model_push();
    pulse_start();
    wait_pulse_over("t6");
`ifdef OV_CFG_TIMEOUT_EN
    t = 0;
    n = 0;
    while (bus.cfg_err !== 1'b1 && n < 3000) begin
      t += int'(bus.iic_clk_en);
      n++;
      @(negedge clock_in);
    end
    chk("t6_timeout_ticks", 32'(t), 256);
    chk("t6_err_busy", 32'(bus.busy), 0);
    chk("t6_err_enable", 32'(bus.iic_enable), 0);
    chk("t6_err_done", 32'(bus.cfg_done), 0);
    eng_respond = 1'b1;
    model_push();
    pulse_start();
    chk("t6_err_clr", 32'(bus.cfg_err), 0);
    run_to_end("t6", mx);
    chk("t6_cfg_done", 32'(bus.cfg_done), 1);
`else
    repeat (300 * CLK_DIV) @(negedge clock_in);
    chk("t6_busy_hold", 32'(bus.busy), 1);
    chk("t6_no_err", 32'(bus.cfg_err), 0);
    chk("t6_no_done", 32'(bus.cfg_done), 0);
    reset_in = 1'b1;
    exp_q.delete();
    repeat (2) @(negedge clock_in);
    reset_in = 1'b0;
    eng_respond = 1'b1;
`endif

    // ---------------- report ----------------
    repeat (4) @(negedge clock_in);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
